// File: rtl/pair_pack_pkg.sv
// Shared types and default lane widths for the pair packer and the lane splitter it feeds.
// Widths match the splitter's 10-bit position / 14-bit threshold lanes.
package pair_pack_pkg;

    localparam int POS_W_DEF = 10;
    localparam int TH_W_DEF  = 14;

    typedef enum logic {
        LOW_WAIT  = 1'b0,
        HIGH_WAIT = 1'b1
    } pp_state_t;

    // One packed word as seen by the splitter: {high, low} per field plus the odd flag.
    typedef struct packed {
        logic [2*POS_W_DEF-1:0] pos;
        logic [2*TH_W_DEF-1:0]  thresh;
        logic                   odd;
    } pack_word_t;

endpackage

// File: rtl/pair_pack.sv
// Packs two consecutive (position, threshold) samples into one {high, low} word behind a
// registered valid/ready output; a burst-ending sample with no partner goes out alone as odd.
module pair_pack
    import pair_pack_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int TH_W  = TH_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [POS_W-1:0]   in_pos,
    input  logic [TH_W-1:0]    in_thresh,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*POS_W-1:0] pos,
    output logic [2*TH_W-1:0]  thresh,
    output logic               out_odd,
    output logic [CNT_W-1:0]   word_cnt
);

    pp_state_t        state, state_nxt;
    logic [POS_W-1:0] lane_pos;
    logic [TH_W-1:0]  lane_th;
    logic             slot_free;
    logic             lane_we;
    logic             load;
    logic             out_hs;

    assign slot_free = !out_valid || out_ready;
    assign out_hs    = out_valid && out_ready;

    // A low non-last sample only fills the lane register, so it never waits on the output slot.
    always_comb begin
        state_nxt = state;
        in_ready  = slot_free;
        lane_we   = 1'b0;
        load      = 1'b0;
        if (state == LOW_WAIT) begin
            if (!in_last) begin
                in_ready = 1'b1;
                if (in_valid) begin
                    lane_we   = 1'b1;
                    state_nxt = HIGH_WAIT;
                end
            end else if (in_valid && slot_free) begin
                load = 1'b1;
            end
        end else begin
            if (in_valid && slot_free) begin
                load      = 1'b1;
                state_nxt = LOW_WAIT;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) state <= LOW_WAIT;
        else      state <= state_nxt;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            lane_pos  <= '0;
            lane_th   <= '0;
            out_valid <= 1'b0;
            pos       <= '0;
            thresh    <= '0;
            out_odd   <= 1'b0;
            word_cnt  <= '0;
        end else begin
            if (lane_we) begin
                lane_pos <= in_pos;
                lane_th  <= in_thresh;
            end
            // A load in the same cycle as a handshake replaces the departing word.
            if (load) begin
                out_valid <= 1'b1;
                if (state == HIGH_WAIT) begin
                    pos     <= {in_pos, lane_pos};
                    thresh  <= {in_thresh, lane_th};
                    out_odd <= 1'b0;
                end else begin
                    pos     <= {{POS_W{1'b0}}, in_pos};
                    thresh  <= {{TH_W{1'b0}}, in_thresh};
                    out_odd <= 1'b1;
                end
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (out_hs) word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pair_pack.sv
// Directed plus random bench for pair_pack against a sample-level pairing model.
module tb_pair_pack;
    import pair_pack_pkg::*;

    localparam int PW = 10;
    localparam int TW = 14;
    localparam int CW = 3;

    logic          iclk = 1'b0;
    logic          irst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pos;
    logic [TW-1:0] in_thresh;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [2*PW-1:0] pos;
    logic [2*TW-1:0] thresh;
    logic          out_odd;
    logic [CW-1:0] word_cnt;

    pair_pack #(.POS_W(PW), .TH_W(TW), .CNT_W(CW)) dut (
        .iclk(iclk), .irst(irst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_thresh(in_thresh), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .pos(pos), .thresh(thresh),
        .out_odd(out_odd), .word_cnt(word_cnt)
    );

    always #5 iclk = ~iclk;

    int n_assert = 0;
    int n_fail   = 0;

    // model: optional held low sample, words produced but not yet taken, words taken
    logic          has_low;
    logic [PW-1:0] low_p;
    logic [TW-1:0] low_t;
    pack_word_t    exp_q[$];
    int            taken;
    logic          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        has_low = 1'b0;
        low_p   = '0;
        low_t   = '0;
        exp_q.delete();
        taken   = 0;
    endtask

    // One clock: check in_ready before the edge, then outputs just after it.
    task automatic step();
        logic          acc, hs, exp_rdy, stall;
        logic [2*PW-1:0] p0;
        logic [2*TW-1:0] t0;
        logic          o0;
        pack_word_t    w;
        #1;
        exp_rdy = (!has_low && !in_last) ? 1'b1 : (!out_valid || out_ready);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc   = in_valid && in_ready && !irst;
        hs    = out_valid && out_ready && !irst;
        stall = out_valid && !out_ready && !irst;
        p0 = pos; t0 = thresh; o0 = out_odd;
        if (hs) begin
            if (exp_q.size() == 0) chk("hs_unexpected", 64'(1), 64'(0));
            else begin
                w = exp_q.pop_front();
                chk("hs_pos", 64'(p0), 64'(w.pos));
                chk("hs_thresh", 64'(t0), 64'(w.thresh));
                chk("hs_odd", 64'(o0), 64'(w.odd));
                taken++;
            end
        end
        if (acc) begin
            if (has_low) begin
                w.pos = {in_pos, low_p}; w.thresh = {in_thresh, low_t}; w.odd = 1'b0;
                exp_q.push_back(w);
                has_low = 1'b0;
            end else if (in_last) begin
                w.pos = {10'd0, in_pos}; w.thresh = {14'd0, in_thresh}; w.odd = 1'b1;
                exp_q.push_back(w);
            end else begin
                has_low = 1'b1; low_p = in_pos; low_t = in_thresh;
            end
        end
        last_acc = acc;
        if (irst) model_reset();
        @(posedge iclk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("word_cnt", 64'(word_cnt), 64'(taken % (1 << CW)));
        if (exp_q.size() != 0) begin
            chk("out_pos", 64'(pos), 64'(exp_q[$].pos));
            chk("out_thresh", 64'(thresh), 64'(exp_q[$].thresh));
            chk("out_odd", 64'(out_odd), 64'(exp_q[$].odd));
        end else if (irst) begin
            chk("rst_pos", 64'(pos), 64'(0));
            chk("rst_thresh", 64'(thresh), 64'(0));
            chk("rst_odd", 64'(out_odd), 64'(0));
        end
        if (stall) begin
            chk("hold_pos", 64'(pos), 64'(p0));
            chk("hold_thresh", 64'(thresh), 64'(t0));
            chk("hold_odd", 64'(out_odd), 64'(o0));
        end
    endtask

    task automatic send(input int p, input int t, input logic last);
        int n = 0;
        in_valid = 1'b1; in_pos = PW'(p); in_thresh = TW'(t); in_last = last;
        do begin
            step();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset();
        irst = 1'b1;
        step();
        step();
        irst = 1'b0;
    endtask

    initial begin
        irst = 1'b1; in_valid = 1'b0; in_pos = '0; in_thresh = '0; in_last = 1'b0;
        out_ready = 1'b1; last_acc = 1'b0;
        model_reset();
        #2;
        do_reset();

        // basic pair
        send(5, 100, 1'b0);
        send(7, 200, 1'b0);
        chk("pair_pos", 64'(pos), 64'h01C05);
        chk("pair_thresh", 64'(thresh), 64'({14'd200, 14'd100}));
        chk("pair_odd", 64'(out_odd), 64'(0));
        step();
        chk("pair_cnt", 64'(word_cnt), 64'(1));

        // odd flush
        send(9, 300, 1'b1);
        chk("odd_pos", 64'(pos), 64'h00009);
        chk("odd_thresh", 64'(thresh), 64'(300));
        chk("odd_valid", 64'(out_valid), 64'(1));
        chk("odd_flag", 64'(out_odd), 64'(1));
        step();

        // backpressure: low sample passes, completing sample stalls
        out_ready = 1'b0;
        send(11, 111, 1'b0);
        send(12, 122, 1'b0);
        send(13, 133, 1'b0);
        in_valid = 1'b1; in_pos = 10'd14; in_thresh = 14'd144;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_acc", 64'(last_acc), 64'(0));
        end
        out_ready = 1'b1;
        step();
        chk("unstall_acc", 64'(last_acc), 64'(1));
        in_valid = 1'b0;
        step();
        step();

        // streaming 8 samples, one word every two cycles
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_pos = PW'(20 + i); in_thresh = TW'(1000 + i);
            step();
            chk("stream_acc", 64'(last_acc), 64'(1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_cnt", 64'(word_cnt), 64'(4));

        // reset while holding a low sample and a pending word
        out_ready = 1'b0;
        send(30, 3000, 1'b0);
        send(31, 3100, 1'b0);
        send(32, 3200, 1'b0);
        irst = 1'b1;
        step();
        irst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send(40, 4000, 1'b0);
        send(41, 4100, 1'b0);
        chk("mid_rst_pos", 64'(pos), 64'({10'd41, 10'd40}));
        step();
        chk("mid_rst_cnt", 64'(word_cnt), 64'(1));

        // counter wrap: 9 words on a 3-bit counter
        do_reset();
        for (int i = 0; i < 9; i++) send(i, i, 1'b1);
        step();
        chk("wrap_cnt", 64'(word_cnt), 64'(1));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            irst      = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_last   = $urandom_range(0, 3) == 0;
            in_pos    = PW'($urandom);
            in_thresh = TW'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        irst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pair_pack.md
# pair_pack

Upstream packing stage that feeds the lane splitter. Accepts one (position, threshold) sample per handshake and assembles two consecutive samples into one packed word: 20-bit position and 28-bit threshold. The first sample goes to the low lane and the second to the high lane. Drives the splitter's `pos`/`thresh` inputs through a registered valid/ready output with full backpressure support. Odd-length bursts are flushed with an explicit marker.

## Interface
- `POS_W`, 10, width of one position lane
- `TH_W`, 14, width of one threshold lane
- `CNT_W`, 16, width of emitted-word counter

Ports:
- `iclk`  in  1  clock; everything is on the rising edge
- `irst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input sample present
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`
- `in_pos`  in  POS_W  sample position
- `in_thresh`  in  TH_W  sample threshold
- `in_last`  in  1  sample ends a burst; forces emission
- `out_valid`  out  1  packed word present
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`
- `pos`  out  2*POS_W  `{high_pos, low_pos}`
- `thresh`  out  2*TH_W  `{high_th, low_th}`
- `out_odd`  out  1  only the low lane is meaningful; high lanes are zero
- `word_cnt`  out  CNT_W  number of words accepted downstream

## Operation
- State machine with two states:
  - `LOW_WAIT`: no low sample held.
  - `HIGH_WAIT`: low sample held in the lane register.
- `slot_free = !out_valid || out_ready`.
- `in_ready`:
  - In `LOW_WAIT` with `in_last = 0`: 1.
  - Otherwise: equals `slot_free`.
  - Combinational on `in_last`, `out_valid` and `out_ready`. Has no dependence on `in_valid`.
- Accept in `LOW_WAIT`, `in_last = 0`: store the sample in the lane register, then go to `HIGH_WAIT`.
- Accept in `LOW_WAIT`, `in_last = 1`: load the output register with `pos = {0, in_pos}`, `thresh = {0, in_thresh}`, `out_odd = 1`. Stay in `LOW_WAIT`.
- Accept in `HIGH_WAIT` (any `in_last`): load the output register with `pos = {in_pos, lane_pos}`, `thresh = {in_thresh, lane_th}`, `out_odd = 0`. Go to `LOW_WAIT`.
- Output register:
  - `out_valid` sets on load.
  - `out_valid` clears on a downstream handshake with no simultaneous load.
  - Load and handshake in the same cycle: `out_valid` stays 1 and the new data replaces the old.
- While `out_valid && !out_ready`, `pos`, `thresh` and `out_odd` hold stable.
- `word_cnt` increments on each downstream handshake and wraps modulo 2^CNT_W.
- Concatenation is pure bit placement: no arithmetic, no sign extension.

## Timing
- Reset values: state `LOW_WAIT`, lane register 0, `out_valid` 0, `pos` 0, `thresh` 0, `out_odd` 0, `word_cnt` 0.
- While `irst` is high, `in_ready` is still driven by the rule above. Handshakes in that cycle are discarded and do not count as accepted.
- Reset mid-operation drops any held low sample and any pending output word. No partial word is emitted afterwards.
- Latency: the word appears on `pos`/`thresh` with `out_valid = 1` one cycle after the accept of the completing sample (high lane or `in_last`).
- Throughput: with `out_ready` held at 1, one sample is accepted every cycle and one word is emitted every two cycles.
- Backpressure: with `out_valid = 1` and `out_ready = 0`:
  - A `LOW_WAIT` non-last sample is still accepted.
  - A completing sample stalls (`in_ready = 0`) until the slot frees.
- `in_last` on a high-lane sample behaves identically to a normal pair (`out_odd = 0`).

## Structure
- Shared package `pair_pack_pkg`:
  - `POS_W`/`TH_W` defaults, matching the splitter's 10/14.
  - State enum `{LOW_WAIT, HIGH_WAIT}`.
  - Packed-word typedef.
- Single module. No sub-module is warranted; the lane register and the output register sit inline.

## Test plan
- Reset, then samples (5,100), (7,200) with `out_ready = 1` → one cycle after the second accept: `pos = 0x01C05`, `thresh = {14'd200, 14'd100}`, `out_odd = 0`, `word_cnt = 1`.
- Single sample (9,300) with `in_last = 1` → `pos = 0x00009`, `thresh = 300`, `out_odd = 1`. State stays `LOW_WAIT`.
- Hold `out_ready = 0` with one word pending, then present two samples:
  - First is accepted (`in_ready = 1`).
  - Second stalls (`in_ready = 0`) until `out_ready = 1`.
  - The pending word holds stable throughout.
- Continuous stream of 8 samples with `out_ready = 1` → 4 words, no stalls, `word_cnt = 4`.
- Assert `irst` while in `HIGH_WAIT` with one word pending → next cycle all outputs are zero and state is `LOW_WAIT`. A following pair emits correctly with `word_cnt = 1` after handshake.
- Preload the counter near wrap (force, or `CNT_W = 2`) and emit 5 words → `word_cnt` wraps to 1.
